wb_cam_dma: RTL and testbench

- Wishbone master (initiator) that moves camera pixel bytes into system memory without CPU load.
- Accepts an 8-bit pixel stream from the camera capture path.
- Packs four pixels into one 32-bit word, big-endian to match LM32, and issues single-beat Wishbone write cycles to incrementing word addresses.
- Software, through a thin register slave, supplies base address and word count, pulses start, then polls busy/done/err.

---
 rtl/wb_cam_dma.sv | 203 ++++++++++++++++++++
 tb/tb_wb_cam_dma.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cam_dma.sv
// wb_cam_dma: Wishbone write master that packs an 8-bit camera pixel
// stream into big-endian 32-bit words and writes them to consecutive
// word addresses, one single-beat cycle per word.
module wb_cam_dma #(
  parameter int WB_ADR_WIDTH = 32,
  parameter int WB_DAT_WIDTH = 32,
  parameter int CNT_WIDTH    = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WB_ADR_WIDTH-1:0] base_adr,
  input  logic [CNT_WIDTH-1:0]    word_count,
  input  logic [7:0]              pix_data,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [WB_ADR_WIDTH-1:0] wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0] wb_dat_o,
  output logic [3:0]              wb_sel_o,
  output logic                    wb_we_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  localparam logic [7:0]              TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_STEP = WB_ADR_WIDTH'(4);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_MASK = ~(WB_ADR_WIDTH'(3));
  localparam logic [CNT_WIDTH-1:0]    CNT_ONE  = CNT_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [WB_ADR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]    remaining_q, remaining_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [23:0]             pack_q, pack_d;
  logic [7:0]              tmo_q, tmo_d;
  logic                    pix_ready_q, pix_ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    bus_q, bus_d;
  logic [3:0]              sel_q, sel_d;
  logic [WB_ADR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DAT_WIDTH-1:0] dat_q, dat_d;

  logic accept;
  logic in_write;
  logic tmo_hit;
  logic abort;
  logic last_word;

  assign accept    = (state_q == FILL) && pix_ready_q && pix_valid;
  assign in_write  = (state_q == WRITE);
  assign tmo_hit   = in_write && !wb_ack_i && !wb_err_i && (tmo_q == TMO_LAST);
  assign abort     = in_write && (wb_err_i || tmo_hit);
  assign last_word = (remaining_q == CNT_ONE);

  assign pix_ready = pix_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = bus_q;
  assign wb_cyc_o  = bus_q;
  assign wb_stb_o  = bus_q;

  // State and datapath registers; reset clears everything and drops the bus at once
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      byte_idx_q  <= '0;
      pack_q      <= '0;
      tmo_q       <= '0;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bus_q       <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      byte_idx_q  <= byte_idx_d;
      pack_q      <= pack_d;
      tmo_q       <= tmo_d;
      pix_ready_q <= pix_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      bus_q       <= bus_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
    end
  end

  // Next-state: collect four bytes, write one word, repeat until count or abort
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && (word_count != '0)) state_d = FILL;
      end
      FILL: begin
        if (accept && (byte_idx_q == 2'd3)) state_d = WRITE;
      end
      WRITE: begin
        if (abort)         state_d = IDLE;
        else if (wb_ack_i) state_d = last_word ? IDLE : FILL;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath: byte packing, bus launch, termination and status flags
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    byte_idx_d  = byte_idx_q;
    pack_d      = pack_q;
    tmo_d       = tmo_q;
    pix_ready_d = pix_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    bus_d       = bus_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (word_count != '0) begin
            addr_d      = base_adr & ADR_MASK;
            remaining_d = word_count;
            byte_idx_d  = 2'd0;
            busy_d      = 1'b1;
            pix_ready_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (accept) begin
          unique case (byte_idx_q)
            2'd0: pack_d[23:16] = pix_data;
            2'd1: pack_d[15:8]  = pix_data;
            2'd2: pack_d[7:0]   = pix_data;
            default: begin
              dat_d       = {pack_q, pix_data};
              adr_d       = addr_q;
              sel_d       = 4'hF;
              bus_d       = 1'b1;
              pix_ready_d = 1'b0;
              tmo_d       = 8'd0;
            end
          endcase
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      WRITE: begin
        if (abort) begin
          bus_d       = 1'b0;
          busy_d      = 1'b0;
          err_d       = 1'b1;
          pix_ready_d = 1'b0;
        end else if (wb_ack_i) begin
          bus_d       = 1'b0;
          addr_d      = addr_q + ADR_STEP;
          remaining_d = remaining_q - CNT_ONE;
          if (last_word) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            pix_ready_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: begin
        bus_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_cam_dma.sv
// tb_wb_cam_dma: randomized scoreboard bench for wb_cam_dma. Expected
// Wishbone writes are derived from the byte stream and start address;
// a monitor pops them as write cycles appear on the bus.
module tb_wb_cam_dma;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  typedef struct {
    int kind;
    int delay;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_adr = '0;
  logic [15:0] word_count = '0;
  logic [7:0]  pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        pix_ready, busy, done, err;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;

  exp_t  expQ[$];
  resp_t respQ[$];
  int    checkCnt = 0;
  int    passCnt = 0;
  int    doneCnt = 0;
  int    cycLen = 0;
  int    lastCycLen = 0;
  logic  prevCyc = 1'b0;
  logic [31:0] curAdr = '0;
  logic [31:0] curDat = '0;
  exp_t  monExp;
  resp_t cur;
  logic  respActive = 1'b0;
  int    respWait = 0;

  wb_cam_dma #(
    .WB_ADR_WIDTH(32),
    .WB_DAT_WIDTH(32),
    .CNT_WIDTH(16),
    .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_adr(base_adr),
    .word_count(word_count),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .busy(busy),
    .done(done),
    .err(err),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checkCnt++;
    if (act === expv) passCnt++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
  endtask

  // Bus monitor: each new write cycle is matched against the scoreboard head,
  // and the bus must stay stable with pix_ready low while the cycle is open
  always @(negedge clk) begin
    if (wb_cyc_o) begin
      if (!prevCyc) begin
        checkOutput("write_expected", 32'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          monExp = expQ.pop_front();
          checkOutput("wb_adr", wb_adr_o, monExp.adr);
          checkOutput("wb_dat", wb_dat_o, monExp.dat);
          checkOutput("wb_sel", 32'(wb_sel_o), 32'hF);
        end
        curAdr = wb_adr_o;
        curDat = wb_dat_o;
        cycLen = 0;
      end else begin
        checkOutput("adr_hold", wb_adr_o, curAdr);
        checkOutput("dat_hold", wb_dat_o, curDat);
      end
      checkOutput("stb_with_cyc", 32'(wb_stb_o), 1);
      checkOutput("we_with_cyc", 32'(wb_we_o), 1);
      checkOutput("pix_ready_in_write", 32'(pix_ready), 0);
      cycLen++;
    end else if (prevCyc) begin
      lastCycLen = cycLen;
    end
    if (done) doneCnt++;
    prevCyc = wb_cyc_o;
  end

  // Slave responder: each bus cycle consumes one scripted response (delay + kind)
  always @(negedge clk) begin
    if (wb_ack_i || wb_err_i) begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      respActive = 1'b0;
    end else if (wb_cyc_o && wb_stb_o) begin
      if (!respActive) begin
        respActive = 1'b1;
        respWait = 0;
        if (respQ.size() > 0) cur = respQ.pop_front();
        else begin
          cur.kind = K_ACK;
          cur.delay = 0;
        end
      end
      if (cur.kind != K_NONE && respWait >= cur.delay) begin
        wb_ack_i = (cur.kind == K_ACK) || (cur.kind == K_BOTH);
        wb_err_i = (cur.kind == K_ERR) || (cur.kind == K_BOTH);
      end else begin
        respWait++;
      end
    end else begin
      respActive = 1'b0;
    end
  end

  task automatic pulseStart(input logic [31:0] b, input logic [15:0] wc);
    @(negedge clk);
    start = 1'b1;
    base_adr = b;
    word_count = wc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int waited = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    pix_valid = 1'b1;
    pix_data = b;
    while (!pix_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("pix_ready_wait_bound", 32'(waited < 2000), 1);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int waited = 0;
    while (busy && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("busy_wait_bound", 32'(waited < 5000), 1);
  endtask

  // One transfer: build the expected writes and slave script, run it, check status
  task automatic applyStimulus(input logic [31:0] base, input int wc, input int abortBeat,
                               input int abortKind, input bit gaps, input int maxDelay,
                               input bit midStart, input bit fixedPattern);
    logic [7:0]  pixBytes[$];
    logic [7:0]  b;
    logic [31:0] w;
    exp_t        e;
    resp_t       r;
    int          nWords;
    int          doneBefore;
    bit          aborted;
    aborted = (abortBeat >= 0);
    nWords = aborted ? abortBeat + 1 : wc;
    for (int i = 0; i < nWords; i++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        b = fixedPattern ? 8'(17 * (4 * i + j + 1)) : 8'($urandom_range(0, 255));
        pixBytes.push_back(b);
        w = w * 256 + 32'(b);
      end
      e.adr = (base - (base % 4)) + 32'(4 * i);
      e.dat = w;
      expQ.push_back(e);
      r.kind = (i == abortBeat) ? abortKind : K_ACK;
      r.delay = fixedPattern ? maxDelay : int'($urandom_range(0, maxDelay));
      respQ.push_back(r);
    end
    doneBefore = doneCnt;
    pulseStart(base, 16'(wc));
    checkOutput("busy_after_start", 32'(busy), 1);
    checkOutput("err_cleared_by_start", 32'(err), 0);
    for (int k = 0; k < pixBytes.size(); k++) begin
      if (midStart && k == 2) pulseStart($urandom, 16'd7);
      sendByte(pixBytes[k], gaps);
    end
    waitIdle();
    @(negedge clk);
    checkOutput("done_pulses", 32'(doneCnt - doneBefore), aborted ? 0 : 1);
    checkOutput("err_flag", 32'(err), 32'(aborted));
    checkOutput("busy_end", 32'(busy), 0);
    checkOutput("done_is_pulse", 32'(done), 0);
    checkOutput("cyc_end", 32'(wb_cyc_o), 0);
    checkOutput("writes_outstanding", 32'(expQ.size()), 0);
    checkOutput("responses_unused", 32'(respQ.size()), 0);
    if (aborted && abortKind == K_NONE) checkOutput("timeout_cycles", 32'(lastCycLen), 255);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_pix_ready"}, 32'(pix_ready), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_err"}, 32'(err), 0);
    checkOutput({tag, "_cyc"}, 32'(wb_cyc_o), 0);
    checkOutput({tag, "_stb"}, 32'(wb_stb_o), 0);
    checkOutput({tag, "_we"}, 32'(wb_we_o), 0);
    checkOutput({tag, "_sel"}, 32'(wb_sel_o), 0);
    checkOutput({tag, "_adr"}, wb_adr_o, 0);
    checkOutput({tag, "_dat"}, wb_dat_o, 0);
  endtask

  // Main sequence
  initial begin
    exp_t e;
    resp_t r;
    int doneBefore;
    $display("[TB] starting wb_cam_dma bench");
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;

    $display("[TB] single word, fixed bytes, one wait state");
    applyStimulus(32'h0000_1003, 1, -1, K_ACK, 1'b0, 1, 1'b0, 1'b1);

    $display("[TB] three words with pixel gaps and random ack delays");
    applyStimulus(32'h0000_2000, 3, -1, K_ACK, 1'b1, 5, 1'b0, 1'b0);

    $display("[TB] ack never arrives");
    applyStimulus(32'h0000_3000, 1, 0, K_NONE, 1'b0, 0, 1'b0, 1'b0);

    $display("[TB] next start clears err");
    applyStimulus(32'h0000_4000, 1, -1, K_ACK, 1'b0, 2, 1'b0, 1'b0);

    $display("[TB] err and ack together on beat 2 of 4");
    applyStimulus(32'h0000_6000, 4, 1, K_BOTH, 1'b1, 3, 1'b0, 1'b0);

    $display("[TB] zero word count");
    doneBefore = doneCnt;
    pulseStart(32'h0000_7000, 16'd0);
    checkOutput("zero_count_done", 32'(done), 1);
    checkOutput("zero_count_busy", 32'(busy), 0);
    checkOutput("zero_count_err_cleared", 32'(err), 0);
    @(negedge clk);
    checkOutput("zero_count_done_drops", 32'(done), 0);

    $display("[TB] start pulse during a transfer is ignored");
    applyStimulus(32'h0000_3000, 2, -1, K_ACK, 1'b1, 2, 1'b1, 1'b0);

    $display("[TB] reset during an open write");
    e.adr = 32'h0000_5000;
    e.dat = 32'hA0A1_A2A3;
    expQ.push_back(e);
    r.kind = K_NONE;
    r.delay = 0;
    respQ.push_back(r);
    pulseStart(32'h0000_5000, 16'd1);
    for (int k = 0; k < 4; k++) sendByte(8'(8'hA0 + k), 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("cyc_before_reset", 32'(wb_cyc_o), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetOutputs("mid_reset");
    checkOutput("mid_reset_writes_outstanding", 32'(expQ.size()), 0);

    $display("[TB] address wrap");
    applyStimulus(32'hFFFF_FFFC, 2, -1, K_ACK, 1'b0, 1, 1'b0, 1'b0);

    $display("[TB] random transfers");
    for (int t = 0; t < 6; t++) begin
      applyStimulus($urandom, int'($urandom_range(1, 3)), -1, K_ACK, 1'b1, 5, 1'b0, 1'b0);
    end
    applyStimulus($urandom, 3, int'($urandom_range(0, 2)), K_ERR, 1'b1, 4, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
